dual_mac_sched: RTL and testbench

Round-robin scheduler that shares one dual-product multiply-accumulate datapath between N_REQ requesters. Each requester streams bursts of operand beats {a1, a2, b1, b2}. The block computes a1*b1 + a2*b2 for each beat and accumulates the burst. It then returns one accumulated result tagged with the requester ID. It sits between the operand sources and the downstream result consumer.

---
 rtl/dual_mac_pkg.sv | 18 +
 rtl/dual_mac_sched_if.sv | 34 +++
 rtl/dual_mac_pipe.sv | 88 ++++++++
 rtl/dual_mac_sched.sv | 146 ++++++++++++++
 tb/tb_dual_mac_sched.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/dual_mac_pkg.sv
// Shared widths, FSM state encoding and operand bundle for the dual-product MAC scheduler.
package dual_mac_pkg;

  localparam int A_W    = 5;
  localparam int B_W    = 8;
  localparam int PROD_W = 13;
  localparam int PSUM_W = 14;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, RESULT} dms_state_t;

  typedef struct packed {
    logic signed [A_W-1:0] a1;
    logic signed [A_W-1:0] a2;
    logic signed [B_W-1:0] b1;
    logic signed [B_W-1:0] b2;
  } operand_t;

endpackage

// File: rtl/dual_mac_sched_if.sv
// Requester/consumer bus of dual_mac_sched; master = operand sources + result sink, slave = scheduler.
interface dual_mac_sched_if
  import dual_mac_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ACC_W = 20
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_last;
  logic [N_REQ*A_W-1:0] req_a1;
  logic [N_REQ*A_W-1:0] req_a2;
  logic [N_REQ*B_W-1:0] req_b1;
  logic [N_REQ*B_W-1:0] req_b2;
  logic [N_REQ-1:0]     req_ready;
  logic                 res_valid;
  logic                 res_ready;
  logic [ID_W-1:0]      res_id;
  logic [ACC_W-1:0]     res_acc;
  logic                 res_ovf;
  logic                 busy;

  modport master (
    output req_valid, req_last, req_a1, req_a2, req_b1, req_b2, res_ready,
    input  req_ready, res_valid, res_id, res_acc, res_ovf, busy
  );

  modport slave (
    input  req_valid, req_last, req_a1, req_a2, req_b1, req_b2, res_ready,
    output req_ready, res_valid, res_id, res_acc, res_ovf, busy
  );

endinterface

// File: rtl/dual_mac_pipe.sv
// Two-stage datapath: stage 1 registers a1*b1 and a2*b2, stage 2 accumulates their sum.
// DUAL_MAC_SAT_EN selects a saturating accumulate with a sticky overflow flag; otherwise it wraps.
module dual_mac_pipe
  import dual_mac_pkg::*;
#(
  parameter int ACC_W = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clear,
  input  logic                    i_beat,
  input  operand_t                i_op,
  output logic signed [ACC_W-1:0] o_acc,
  output logic                    o_ovf
);

  logic signed [PROD_W-1:0] w_p1;
  logic signed [PROD_W-1:0] w_p2;
  logic signed [PROD_W-1:0] r_p1;
  logic signed [PROD_W-1:0] r_p2;
  logic                     r_v1;
  logic signed [PSUM_W-1:0] w_psum;
  logic signed [ACC_W-1:0]  w_acc_nxt;
  logic signed [ACC_W-1:0]  r_acc;

  // Operands are widened to the product width first so -16 * -128 stays exact.
  assign w_p1   = PROD_W'($signed(i_op.a1)) * PROD_W'($signed(i_op.b1));
  assign w_p2   = PROD_W'($signed(i_op.a2)) * PROD_W'($signed(i_op.b2));
  assign w_psum = PSUM_W'(r_p1) + PSUM_W'(r_p2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p1 <= '0;
      r_p2 <= '0;
      r_v1 <= 1'b0;
    end else if (i_clear) begin
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= i_beat;
      if (i_beat) begin
        r_p1 <= w_p1;
        r_p2 <= w_p2;
      end
    end
  end

`ifdef DUAL_MAC_SAT_EN
  logic signed [ACC_W:0] w_wide;
  logic                  w_clamp;
  logic                  r_ovf;

  assign w_wide = (ACC_W+1)'(r_acc) + (ACC_W+1)'(w_psum);

  // One guard bit: overflow shows up as the top two bits disagreeing.
  always_comb begin
    w_clamp   = 1'b0;
    w_acc_nxt = w_wide[ACC_W-1:0];
    if (w_wide[ACC_W] != w_wide[ACC_W-1]) begin
      w_clamp   = 1'b1;
      w_acc_nxt = w_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_ovf <= 1'b0;
    end else if (r_v1 && w_clamp) begin
      r_ovf <= 1'b1;
    end
  end

  assign o_ovf = r_ovf;
`else
  assign w_acc_nxt = r_acc + ACC_W'(w_psum);
  assign o_ovf     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_acc <= '0;
    end else if (r_v1) begin
      r_acc <= w_acc_nxt;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/dual_mac_sched.sv
// Round-robin scheduler sharing one dual-product MAC pipeline between N_REQ burst requesters.
// Optional saturation (DUAL_MAC_SAT_EN) lives in dual_mac_pipe.
//
// state  | meaning
// IDLE   | no grant; pick next requester from rr_ptr upward, clear accumulator
// RUN    | granted requester streams beats; ends on last beat or MAX_BEATS
// DRAIN  | two cycles while the pipeline empties, no beats accepted
// RESULT | hold result until consumer handshake, then advance rr_ptr
module dual_mac_sched
  import dual_mac_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int ACC_W     = 20,
  parameter int MAX_BEATS = 16
) (
  input  logic           clk,
  input  logic           rst,
  dual_mac_sched_if.slave bus
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int BC_W = $clog2(MAX_BEATS + 1);
  localparam logic [BC_W-1:0] BEAT_TC = BC_W'(MAX_BEATS - 1);

  dms_state_t              r_state;
  dms_state_t              w_state_nxt;
  logic [ID_W-1:0]         r_rr_ptr;
  logic [ID_W-1:0]         r_gid;
  logic [BC_W-1:0]         r_beat_cnt;
  logic                    r_drain_cnt;
  logic [ID_W-1:0]         w_arb_idx;
  logic                    w_grant;
  logic                    w_beat;
  logic [N_REQ-1:0]        w_ready;
  operand_t                w_op;
  logic signed [ACC_W-1:0] w_acc;
  logic                    w_ovf;

  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                               input logic [ID_W-1:0]  ptr);
    logic [ID_W-1:0] pick;
    logic            found;
    int              idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!found && valid[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
    return pick;
  endfunction

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == ID_W'(N_REQ - 1)) ? '0 : id + ID_W'(1);
  endfunction

  assign w_arb_idx = rr_pick(bus.req_valid, r_rr_ptr);

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_beat      = 1'b0;
    w_ready     = '0;
    unique case (r_state)
      IDLE: begin
        if (|bus.req_valid) begin
          w_grant     = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_ready[r_gid] = 1'b1;
        w_beat         = bus.req_valid[r_gid];
        if (w_beat && (bus.req_last[r_gid] || r_beat_cnt == BEAT_TC)) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (r_drain_cnt == 1'b0) begin
          w_state_nxt = RESULT;
        end
      end
      RESULT: begin
        if (bus.res_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_gid       <= '0;
      r_beat_cnt  <= '0;
      r_drain_cnt <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_gid      <= w_arb_idx;
        r_beat_cnt <= '0;
      end else if (w_beat) begin
        r_beat_cnt <= r_beat_cnt + BC_W'(1);
      end
      // Drain is a two-cycle down-counter loaded as the burst closes.
      if (r_state == RUN && w_state_nxt == DRAIN) begin
        r_drain_cnt <= 1'b1;
      end else if (r_state == DRAIN && r_drain_cnt != 1'b0) begin
        r_drain_cnt <= r_drain_cnt - 1'b1;
      end
      if (r_state == RESULT && bus.res_ready) begin
        r_rr_ptr <= next_id(r_gid);
      end
    end
  end

  assign w_op.a1 = bus.req_a1[int'(r_gid)*A_W +: A_W];
  assign w_op.a2 = bus.req_a2[int'(r_gid)*A_W +: A_W];
  assign w_op.b1 = bus.req_b1[int'(r_gid)*B_W +: B_W];
  assign w_op.b2 = bus.req_b2[int'(r_gid)*B_W +: B_W];

  dual_mac_pipe #(
    .ACC_W(ACC_W)
  ) u_pipe (
    .clk    (clk),
    .rst    (rst),
    .i_clear(w_grant),
    .i_beat (w_beat),
    .i_op   (w_op),
    .o_acc  (w_acc),
    .o_ovf  (w_ovf)
  );

  assign bus.req_ready = w_ready;
  assign bus.res_valid = (r_state == RESULT);
  assign bus.res_id    = r_gid;
  assign bus.res_acc   = w_acc;
  assign bus.res_ovf   = w_ovf;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_dual_mac_sched.sv
// Directed bench for dual_mac_sched: instance A (ACC_W=16, MAX_BEATS=16), instance B (MAX_BEATS=4).
module tb_dual_mac_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dual_mac_sched_if #(.N_REQ(4), .ACC_W(16)) a_if ();
  dual_mac_sched_if #(.N_REQ(4), .ACC_W(20)) b_if ();

  dual_mac_sched #(.N_REQ(4), .ACC_W(16), .MAX_BEATS(16)) u_dut_a (
    .clk(clk), .rst(rst), .bus(a_if.slave)
  );
  dual_mac_sched #(.N_REQ(4), .ACC_W(20), .MAX_BEATS(4)) u_dut_b (
    .clk(clk), .rst(rst), .bus(b_if.slave)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit rdy(input bit sel, input int id);
    return sel ? b_if.req_ready[id] : a_if.req_ready[id];
  endfunction

  function automatic bit resv(input bit sel);
    return sel ? b_if.res_valid : a_if.res_valid;
  endfunction

  // Present one beat from requester id and hold it until accepted.
  task automatic beat(input bit sel, input int id, input int a1, input int a2,
                      input int b1, input int b2, input bit last);
    int n;
    if (sel) begin
      b_if.req_a1[id*5 +: 5] = 5'(a1);
      b_if.req_a2[id*5 +: 5] = 5'(a2);
      b_if.req_b1[id*8 +: 8] = 8'(b1);
      b_if.req_b2[id*8 +: 8] = 8'(b2);
      b_if.req_last[id]      = last;
      b_if.req_valid[id]     = 1'b1;
    end else begin
      a_if.req_a1[id*5 +: 5] = 5'(a1);
      a_if.req_a2[id*5 +: 5] = 5'(a2);
      a_if.req_b1[id*8 +: 8] = 8'(b1);
      a_if.req_b2[id*8 +: 8] = 8'(b2);
      a_if.req_last[id]      = last;
      a_if.req_valid[id]     = 1'b1;
    end
    n = 0;
    while (!rdy(sel, id) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("beat_accept", longint'(rdy(sel, id)), 1);
    @(negedge clk);
    if (sel) begin
      b_if.req_valid[id] = 1'b0;
      b_if.req_last[id]  = 1'b0;
    end else begin
      a_if.req_valid[id] = 1'b0;
      a_if.req_last[id]  = 1'b0;
    end
  endtask

  task automatic get_res(input bit sel, input int exp_id, input int exp_acc,
                         input int exp_ovf, input string tag);
    int n;
    n = 0;
    while (!resv(sel) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, longint'(resv(sel)), 1);
    if (sel) begin
      chk({tag, "_id"},  longint'(b_if.res_id), exp_id);
      chk({tag, "_acc"}, longint'($signed(b_if.res_acc)), exp_acc);
      chk({tag, "_ovf"}, longint'(b_if.res_ovf), exp_ovf);
      b_if.res_ready = 1'b1;
      @(negedge clk);
      b_if.res_ready = 1'b0;
    end else begin
      chk({tag, "_id"},  longint'(a_if.res_id), exp_id);
      chk({tag, "_acc"}, longint'($signed(a_if.res_acc)), exp_acc);
      chk({tag, "_ovf"}, longint'(a_if.res_ovf), exp_ovf);
      a_if.res_ready = 1'b1;
      @(negedge clk);
      a_if.res_ready = 1'b0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_res_valid"}, longint'(a_if.res_valid), 0);
    chk({tag, "_req_ready"}, longint'(a_if.req_ready), 0);
    chk({tag, "_busy"},      longint'(a_if.busy), 0);
    chk({tag, "_res_id"},    longint'(a_if.res_id), 0);
    chk({tag, "_res_acc"},   longint'($signed(a_if.res_acc)), 0);
    chk({tag, "_res_ovf"},   longint'(a_if.res_ovf), 0);
  endtask

  initial begin
    int n;
    int exp_wrap_acc;
    int exp_wrap_ovf;
`ifdef DUAL_MAC_SAT_EN
    exp_wrap_acc = 32767;
    exp_wrap_ovf = 1;
`else
    exp_wrap_acc = -32768;
    exp_wrap_ovf = 0;
`endif
    a_if.req_valid = '0; a_if.req_last = '0; a_if.res_ready = 1'b0;
    a_if.req_a1 = '0; a_if.req_a2 = '0; a_if.req_b1 = '0; a_if.req_b2 = '0;
    b_if.req_valid = '0; b_if.req_last = '0; b_if.res_ready = 1'b0;
    b_if.req_a1 = '0; b_if.req_a2 = '0; b_if.req_b1 = '0; b_if.req_b2 = '0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset_b_busy", longint'(b_if.busy), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single-beat burst, exact three-cycle result latency.
    beat(1'b0, 0, -16, 15, 127, -128, 1'b1);
    chk("lat_t1", longint'(a_if.res_valid), 0);
    chk("lat_busy", longint'(a_if.busy), 1);
    @(negedge clk);
    chk("lat_t2", longint'(a_if.res_valid), 0);
    @(negedge clk);
    chk("lat_t3", longint'(a_if.res_valid), 1);
    get_res(1'b0, 0, -3952, 0, "single");

    // Round-robin from a fresh pointer: 0, 1, 2, then 0 again.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fork
      begin
        beat(1'b0, 0, 1, 0, 1, 0, 1'b1);
        beat(1'b0, 0, 4, 0, 1, 0, 1'b1);
      end
      beat(1'b0, 1, 2, 0, 1, 0, 1'b1);
      beat(1'b0, 2, 3, 0, 1, 0, 1'b1);
      begin
        get_res(1'b0, 0, 1, 0, "rr0");
        get_res(1'b0, 1, 2, 0, "rr1");
        get_res(1'b0, 2, 3, 0, "rr2");
        get_res(1'b0, 0, 4, 0, "rr3");
      end
    join

    // Backpressure: result held five cycles while another requester waits.
    beat(1'b0, 2, 3, 0, 5, 0, 1'b1);
    n = 0;
    while (!a_if.res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    a_if.req_a1[1*5 +: 5] = 5'd1;
    a_if.req_b1[1*8 +: 8] = 8'd2;
    a_if.req_a2[1*5 +: 5] = 5'd0;
    a_if.req_b2[1*8 +: 8] = 8'd0;
    a_if.req_last[1]      = 1'b1;
    a_if.req_valid[1]     = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", longint'(a_if.res_valid), 1);
      chk("bp_id", longint'(a_if.res_id), 2);
      chk("bp_acc", longint'($signed(a_if.res_acc)), 15);
      chk("bp_ready", longint'(a_if.req_ready), 0);
      @(negedge clk);
    end
    a_if.res_ready = 1'b1;
    @(negedge clk);
    a_if.res_ready = 1'b0;
    chk("bp_done_valid", longint'(a_if.res_valid), 0);
    chk("bp_done_busy", longint'(a_if.busy), 0);
    beat(1'b0, 1, 1, 0, 2, 0, 1'b1);
    get_res(1'b0, 1, 2, 0, "bp_next");

    // Eight beats of 4096 push a 16-bit accumulator past its positive limit.
    for (int i = 1; i <= 8; i++) begin
      beat(1'b0, 0, -16, -16, -128, -128, (i == 8));
    end
    get_res(1'b0, 0, exp_wrap_acc, exp_wrap_ovf, "wrap");

    // Reset in the middle of a burst, then a clean burst from requester 3.
    beat(1'b0, 3, 7, 0, 1, 0, 1'b0);
    beat(1'b0, 3, 7, 0, 1, 0, 1'b0);
    chk("mid_run_ready", longint'(a_if.req_ready), 8);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("mid_rst");
    rst = 1'b0;
    beat(1'b0, 3, 2, 0, 3, 0, 1'b1);
    get_res(1'b0, 3, 6, 0, "post_rst");

    // Forced termination at four beats; remaining two form a second burst.
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          beat(1'b1, 1, 1, 0, 1, 0, (i == 6));
        end
      end
      begin
        get_res(1'b1, 1, 4, 0, "force0");
        get_res(1'b1, 1, 2, 0, "force1");
      end
    join

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
